// File: rtl/pkt_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC pkt_tx_* interface between
// NUM_SRC sources; each packet is forwarded atomically and pkt_tx_full stalls the owner.
module pkt_tx_arbiter #(
    parameter int NUM_SRC = 2
) (
    input  logic                    clk_156m25,
    input  logic                    reset_156m25,
    input  logic [NUM_SRC-1:0]      src_val,
    input  logic [NUM_SRC-1:0]      src_sop,
    input  logic [NUM_SRC-1:0]      src_eop,
    input  logic [3*NUM_SRC-1:0]    src_mod,
    input  logic [64*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_rdy,
    input  logic                    pkt_tx_full,
    output logic                    pkt_tx_val,
    output logic                    pkt_tx_sop,
    output logic                    pkt_tx_eop,
    output logic [2:0]              pkt_tx_mod,
    output logic [63:0]             pkt_tx_data,
    output logic                    err_nosop,
    output logic                    err_sop_mid,
    output logic [15:0]             pkt_cnt
);
    localparam int DATA_W = 64;
    localparam int MOD_W  = 3;
    localparam int OWN_W  = $clog2(NUM_SRC);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [OWN_W-1:0]   owner;
    logic [OWN_W-1:0]   last_owner;
    logic               first_beat;

    logic               beat_vld_p0;
    logic               beat_sop_p0;
    logic               beat_eop_p0;
    logic [MOD_W-1:0]   beat_mod_p0;
    logic [DATA_W-1:0]  beat_data_p0;
    logic               xfer_vld_p0;
    logic               grant_vld;
    logic [OWN_W-1:0]   grant_idx;
    logic               idle_bad_beat;

    // Stage p0: select the owner's beat and decide whether it transfers this cycle
    always_comb begin
        beat_vld_p0  = 1'b0;
        beat_sop_p0  = 1'b0;
        beat_eop_p0  = 1'b0;
        beat_mod_p0  = '0;
        beat_data_p0 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner == OWN_W'(i)) begin
                beat_vld_p0  = src_val[i];
                beat_sop_p0  = src_sop[i];
                beat_eop_p0  = src_eop[i];
                beat_mod_p0  = src_mod[MOD_W*i +: MOD_W];
                beat_data_p0 = src_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready never looks at src_val, so a source may wait on src_rdy without a loop
    always_comb begin
        src_rdy = '0;
        if (state == BUSY && !pkt_tx_full && !reset_156m25) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_rdy[i] = (owner == OWN_W'(i));
            end
        end
    end

    assign xfer_vld_p0   = (state == BUSY) && !pkt_tx_full && beat_vld_p0;
    assign idle_bad_beat = (state == IDLE) && (|(src_val & ~src_sop));

    always_comb begin
        logic [NUM_SRC-1:0] cand;
        logic [OWN_W-1:0]   idx;
        cand      = src_val & src_sop;
        idx       = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = OWN_W'((int'(last_owner) + k) % NUM_SRC);
            if (!grant_vld && cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Stage p1: registered pkt_tx_* outputs, arbitration state and status
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= OWN_W'(NUM_SRC - 1);
            first_beat  <= 1'b0;
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
            pkt_tx_data <= '0;
            pkt_cnt     <= '0;
            err_nosop   <= 1'b0;
            err_sop_mid <= 1'b0;
        end else begin
            pkt_tx_val <= xfer_vld_p0;
            pkt_tx_sop <= xfer_vld_p0 & beat_sop_p0;
            pkt_tx_eop <= xfer_vld_p0 & beat_eop_p0;
            if (xfer_vld_p0) begin
                pkt_tx_mod  <= beat_mod_p0;
                pkt_tx_data <= beat_data_p0;
            end
            if (idle_bad_beat) begin
                err_nosop <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner      <= grant_idx;
                        first_beat <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_vld_p0) begin
                        first_beat <= 1'b0;
                        if (beat_sop_p0 && !first_beat) begin
                            err_sop_mid <= 1'b1;
                        end
                        if (beat_eop_p0) begin
                            pkt_cnt    <= pkt_cnt + 16'd1;
                            last_owner <= owner;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Directed bench for pkt_tx_arbiter (NUM_SRC=2): per-cycle expectations are written
// out by hand for each scenario.
module tb_pkt_tx_arbiter;
    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    src_val, src_sop, src_eop, src_rdy;
    logic [5:0]    src_mod;
    logic [127:0]  src_data;
    logic          full;
    logic          tx_val, tx_sop, tx_eop;
    logic [2:0]    tx_mod;
    logic [63:0]   tx_data;
    logic          err_nosop, err_sop_mid;
    logic [15:0]   pkt_cnt;

    int checks = 0;
    int errors = 0;

    // Per-cycle scenario tables: expected output beat code (-1 = no beat), ready, full
    int         exp_code [16];
    logic [1:0] exp_rdy  [16];
    logic       full_sched [16];

    // Source model: packets left, current packet/beat, packet length
    int         s_left [2];
    int         s_pkt  [2];
    int         s_beat [2];
    int         s_len;
    logic [1:0] s_xfer;

    pkt_tx_arbiter #(.NUM_SRC(2)) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .src_val      (src_val),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .src_mod      (src_mod),
        .src_data     (src_data),
        .src_rdy      (src_rdy),
        .pkt_tx_full  (full),
        .pkt_tx_val   (tx_val),
        .pkt_tx_sop   (tx_sop),
        .pkt_tx_eop   (tx_eop),
        .pkt_tx_mod   (tx_mod),
        .pkt_tx_data  (tx_data),
        .err_nosop    (err_nosop),
        .err_sop_mid  (err_sop_mid),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mk_data(input int code);
        return 64'hCAFE_0000_0000_0000 | 64'(code);
    endfunction

    function automatic logic [2:0] mk_mod(input int b, input int len);
        return (b == len - 1) ? 3'(len - 1) : 3'(b + 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic s, input logic e,
                           input logic [2:0] m, input logic [63:0] d);
        src_val[i]          = v;
        src_sop[i]          = s;
        src_eop[i]          = e;
        src_mod[3*i +: 3]   = m;
        src_data[64*i +: 64] = d;
    endtask

    task automatic clear_src();
        src_val = '0; src_sop = '0; src_eop = '0; src_mod = '0; src_data = '0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        clear_src();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic src_init(input int l0, input int l1, input int len);
        s_left[0] = l0; s_left[1] = l1;
        s_pkt[0]  = 0;  s_pkt[1]  = 0;
        s_beat[0] = 0;  s_beat[1] = 0;
        s_len     = len;
    endtask

    task automatic src_drive();
        for (int i = 0; i < 2; i++) begin
            if (s_left[i] > 0)
                set_src(i, 1'b1, s_beat[i] == 0, s_beat[i] == s_len - 1,
                        mk_mod(s_beat[i], s_len), mk_data(i*256 + s_pkt[i]*16 + s_beat[i]));
            else
                set_src(i, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        end
    endtask

    task automatic src_advance();
        for (int i = 0; i < 2; i++) begin
            if (s_xfer[i]) begin
                s_beat[i]++;
                if (s_beat[i] == s_len) begin
                    s_beat[i] = 0;
                    s_pkt[i]++;
                    s_left[i]--;
                end
            end
        end
    endtask

    task automatic set_tab(input int k, input int code, input logic [1:0] rdy, input logic f);
        exp_code[k] = code; exp_rdy[k] = rdy; full_sched[k] = f;
    endtask

    task automatic test_reset();
        rst = 1'b1; full = 1'b0;
        clear_src();
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h55);
        tick();
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_eop, tx_mod, tx_data} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: val=%b sop=%b eop=%b mod=%0d data=%h, required all 0",
                     tx_val, tx_sop, tx_eop, tx_mod, tx_data);
        end
        checks++;
        if ({pkt_cnt, err_nosop, err_sop_mid} !== 18'd0) begin
            errors++;
            $display("FAIL reset_status: pkt_cnt=%0d err_nosop=%b err_sop_mid=%b, required 0 0 0",
                     pkt_cnt, err_nosop, err_sop_mid);
        end
        checks++;
        if (src_rdy !== 2'b00) begin
            errors++;
            $display("FAIL reset_rdy: src_rdy=%b, required 00", src_rdy);
        end
        clear_src();
        rst = 1'b0;
    endtask

    task automatic test_single_src();
        do_reset();
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hA0);
        #1;
        checks++;
        if (src_rdy !== 2'b00) begin
            errors++; $display("FAIL single_rdy_idle: src_rdy=%b, required 00", src_rdy);
        end
        tick();
        checks++;
        if (src_rdy !== 2'b01 || tx_val !== 1'b0) begin
            errors++; $display("FAIL single_grant: src_rdy=%b val=%b, required 01 0", src_rdy, tx_val);
        end
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_eop, tx_data} !== {3'b110, 64'hA0}) begin
            errors++; $display("FAIL single_beat1: vse=%b%b%b data=%h, required 110 a0", tx_val, tx_sop, tx_eop, tx_data);
        end
        set_src(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'hA1);
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_eop, tx_data} !== {3'b100, 64'hA1}) begin
            errors++; $display("FAIL single_beat2: vse=%b%b%b data=%h, required 100 a1", tx_val, tx_sop, tx_eop, tx_data);
        end
        set_src(0, 1'b1, 1'b0, 1'b1, 3'd5, 64'hA2);
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_eop, tx_mod, tx_data} !== {3'b101, 3'd5, 64'hA2}) begin
            errors++; $display("FAIL single_beat3: vse=%b%b%b mod=%0d data=%h, required 101 5 a2",
                               tx_val, tx_sop, tx_eop, tx_mod, tx_data);
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL single_cnt: pkt_cnt=%0d, required 1", pkt_cnt);
        end
        clear_src();
        #1;
        checks++;
        if (src_rdy !== 2'b00) begin
            errors++; $display("FAIL single_rdy_done: src_rdy=%b, required 00", src_rdy);
        end
        tick();
        checks++;
        if (tx_val !== 1'b0) begin
            errors++; $display("FAIL single_tail: val=%b, required 0", tx_val);
        end
    endtask

    task automatic test_back_to_back();
        int b;
        do_reset();
        src_init(2, 2, 2);
        set_tab(0, -1, 2'b00, 1'b0);     set_tab(1, -1, 2'b01, 1'b0);
        set_tab(2, 'h000, 2'b01, 1'b0);  set_tab(3, 'h001, 2'b00, 1'b0);
        set_tab(4, -1, 2'b10, 1'b0);     set_tab(5, 'h100, 2'b10, 1'b0);
        set_tab(6, 'h101, 2'b00, 1'b0);  set_tab(7, -1, 2'b01, 1'b0);
        set_tab(8, 'h010, 2'b01, 1'b0);  set_tab(9, 'h011, 2'b00, 1'b0);
        set_tab(10, -1, 2'b10, 1'b0);    set_tab(11, 'h110, 2'b10, 1'b0);
        set_tab(12, 'h111, 2'b00, 1'b0); set_tab(13, -1, 2'b00, 1'b0);
        for (int k = 0; k < 14; k++) begin
            b = exp_code[k] & 15;
            checks++;
            if (exp_code[k] < 0) begin
                if ({tx_val, tx_sop, tx_eop} !== 3'b000) begin
                    errors++; $display("FAIL rr_out cycle %0d: vse=%b%b%b, required 000", k, tx_val, tx_sop, tx_eop);
                end
            end else if ({tx_val, tx_sop, tx_eop, tx_mod, tx_data} !==
                         {1'b1, b == 0, b == s_len - 1, mk_mod(b, s_len), mk_data(exp_code[k])}) begin
                errors++; $display("FAIL rr_out cycle %0d: vse=%b%b%b mod=%0d data=%h, required beat code %h",
                                   k, tx_val, tx_sop, tx_eop, tx_mod, tx_data, exp_code[k]);
            end
            full = full_sched[k];
            src_drive();
            #1;
            checks++;
            if (src_rdy !== exp_rdy[k]) begin
                errors++; $display("FAIL rr_rdy cycle %0d: src_rdy=%b, required %b", k, src_rdy, exp_rdy[k]);
            end
            s_xfer = src_val & src_rdy;
            tick();
            src_advance();
        end
        checks++;
        if (pkt_cnt !== 16'd4) begin
            errors++; $display("FAIL rr_cnt: pkt_cnt=%0d, required 4", pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        int b;
        do_reset();
        src_init(1, 0, 4);
        set_tab(0, -1, 2'b00, 1'b0);    set_tab(1, -1, 2'b01, 1'b0);
        set_tab(2, 'h000, 2'b00, 1'b1); set_tab(3, -1, 2'b00, 1'b1);
        set_tab(4, -1, 2'b00, 1'b1);    set_tab(5, -1, 2'b00, 1'b1);
        set_tab(6, -1, 2'b01, 1'b0);    set_tab(7, 'h001, 2'b01, 1'b0);
        set_tab(8, 'h002, 2'b01, 1'b0); set_tab(9, 'h003, 2'b00, 1'b0);
        set_tab(10, -1, 2'b00, 1'b0);
        for (int k = 0; k < 11; k++) begin
            b = exp_code[k] & 15;
            checks++;
            if (exp_code[k] < 0) begin
                if ({tx_val, tx_sop, tx_eop} !== 3'b000) begin
                    errors++; $display("FAIL bp_out cycle %0d: vse=%b%b%b, required 000", k, tx_val, tx_sop, tx_eop);
                end
            end else if ({tx_val, tx_sop, tx_eop, tx_mod, tx_data} !==
                         {1'b1, b == 0, b == s_len - 1, mk_mod(b, s_len), mk_data(exp_code[k])}) begin
                errors++; $display("FAIL bp_out cycle %0d: vse=%b%b%b mod=%0d data=%h, required beat code %h",
                                   k, tx_val, tx_sop, tx_eop, tx_mod, tx_data, exp_code[k]);
            end
            full = full_sched[k];
            src_drive();
            #1;
            checks++;
            if (src_rdy !== exp_rdy[k]) begin
                errors++; $display("FAIL bp_rdy cycle %0d: src_rdy=%b, required %b", k, src_rdy, exp_rdy[k]);
            end
            s_xfer = src_val & src_rdy;
            tick();
            src_advance();
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL bp_cnt: pkt_cnt=%0d, required 1", pkt_cnt);
        end
    endtask

    task automatic test_single_beat();
        int b;
        do_reset();
        src_init(0, 1, 1);
        set_tab(0, -1, 2'b00, 1'b0);    set_tab(1, -1, 2'b10, 1'b0);
        set_tab(2, 'h100, 2'b00, 1'b0); set_tab(3, -1, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            b = exp_code[k] & 15;
            checks++;
            if (exp_code[k] < 0) begin
                if ({tx_val, tx_sop, tx_eop} !== 3'b000) begin
                    errors++; $display("FAIL sb_out cycle %0d: vse=%b%b%b, required 000", k, tx_val, tx_sop, tx_eop);
                end
            end else if ({tx_val, tx_sop, tx_eop, tx_mod, tx_data} !==
                         {1'b1, b == 0, b == s_len - 1, mk_mod(b, s_len), mk_data(exp_code[k])}) begin
                errors++; $display("FAIL sb_out cycle %0d: vse=%b%b%b mod=%0d data=%h, required beat code %h",
                                   k, tx_val, tx_sop, tx_eop, tx_mod, tx_data, exp_code[k]);
            end
            full = full_sched[k];
            src_drive();
            #1;
            checks++;
            if (src_rdy !== exp_rdy[k]) begin
                errors++; $display("FAIL sb_rdy cycle %0d: src_rdy=%b, required %b", k, src_rdy, exp_rdy[k]);
            end
            s_xfer = src_val & src_rdy;
            tick();
            src_advance();
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL sb_cnt: pkt_cnt=%0d, required 1", pkt_cnt);
        end
    endtask

    // Entered with pkt_cnt=1 and source 1 as last owner (left by test_single_beat)
    task automatic test_reset_mid();
        clear_src();
        set_src(0, 1'b1, 1'b1, 1'b1, 3'd0, 64'hB0);
        tick();
        checks++;
        if (src_rdy !== 2'b01) begin
            errors++; $display("FAIL rm_pre_rdy: src_rdy=%b, required 01", src_rdy);
        end
        tick();
        checks++;
        if (pkt_cnt !== 16'd2) begin
            errors++; $display("FAIL rm_pre_cnt: pkt_cnt=%0d, required 2", pkt_cnt);
        end
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hB1);
        tick();
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_data} !== {2'b11, 64'hB1}) begin
            errors++; $display("FAIL rm_beat1: val=%b sop=%b data=%h, required 1 1 b1", tx_val, tx_sop, tx_data);
        end
        set_src(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'hB2);
        rst = 1'b1;
        #1;
        checks++;
        if (src_rdy !== 2'b00) begin
            errors++; $display("FAIL rm_rdy_in_reset: src_rdy=%b, required 00", src_rdy);
        end
        tick();
        checks++;
        if ({tx_val, tx_eop, pkt_cnt} !== 18'd0) begin
            errors++; $display("FAIL rm_abandon: val=%b eop=%b pkt_cnt=%0d, required 0 0 0", tx_val, tx_eop, pkt_cnt);
        end
        rst = 1'b0;
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hC0);
        set_src(1, 1'b1, 1'b1, 1'b0, 3'd0, 64'hD0);
        tick();
        checks++;
        if (src_rdy !== 2'b01) begin
            errors++; $display("FAIL rm_regrant: src_rdy=%b, required 01", src_rdy);
        end
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_data} !== {2'b11, 64'hC0}) begin
            errors++; $display("FAIL rm_first_out: val=%b sop=%b data=%h, required 1 1 c0", tx_val, tx_sop, tx_data);
        end
        clear_src();
    endtask

    task automatic test_errors();
        do_reset();
        set_src(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'hE0);
        #1;
        checks++;
        if ({err_nosop, err_sop_mid, src_rdy} !== 4'b0000) begin
            errors++; $display("FAIL err_initial: nosop=%b sop_mid=%b rdy=%b, required 0 0 00", err_nosop, err_sop_mid, src_rdy);
        end
        tick();
        checks++;
        if (err_nosop !== 1'b1 || src_rdy !== 2'b00) begin
            errors++; $display("FAIL err_nosop_set: nosop=%b rdy=%b, required 1 00", err_nosop, src_rdy);
        end
        tick();
        checks++;
        if (src_rdy !== 2'b00) begin
            errors++; $display("FAIL err_nosop_stall: src_rdy=%b, required 00", src_rdy);
        end
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hE0);
        tick();
        checks++;
        if (src_rdy !== 2'b01) begin
            errors++; $display("FAIL err_grant: src_rdy=%b, required 01", src_rdy);
        end
        tick();
        checks++;
        if (err_sop_mid !== 1'b0) begin
            errors++; $display("FAIL err_first_sop: err_sop_mid=%b, required 0", err_sop_mid);
        end
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hE1);
        tick();
        checks++;
        if ({tx_val, tx_sop, tx_data, err_sop_mid} !== {2'b11, 64'hE1, 1'b1}) begin
            errors++; $display("FAIL err_mid_sop: val=%b sop=%b data=%h sop_mid=%b, required 1 1 e1 1",
                               tx_val, tx_sop, tx_data, err_sop_mid);
        end
        set_src(0, 1'b1, 1'b0, 1'b1, 3'd2, 64'hE2);
        tick();
        checks++;
        if ({tx_val, tx_eop, tx_mod, tx_data, err_nosop, err_sop_mid} !== {2'b11, 3'd2, 64'hE2, 2'b11}) begin
            errors++; $display("FAIL err_sticky: val=%b eop=%b mod=%0d data=%h nosop=%b sop_mid=%b, required 1 1 2 e2 1 1",
                               tx_val, tx_eop, tx_mod, tx_data, err_nosop, err_sop_mid);
        end
        clear_src();
    endtask

    initial begin
        rst  = 1'b1;
        full = 1'b0;
        clear_src();
        test_reset();
        test_single_src();
        test_back_to_back();
        test_backpressure();
        test_single_beat();
        test_reset_mid();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_tx_arbiter.md
# pkt_tx_arbiter

Packet-granular round-robin arbiter that shares the MAC transmit packet interface (pkt_tx_*) between NUM_SRC independent packet sources. It runs in the 156.25 MHz MAC clock domain, in front of the MAC TX FIFO. Each packet is forwarded atomically from SOP to EOP, and the block honours pkt_tx_full backpressure. All pkt_tx_* outputs are registered.

## Interface
- NUM_SRC, default 2: number of sources, legal range 2..4.
- clk_156m25  in  1  MAC clock; all logic is on its rising edge.
- reset_156m25  in  1  synchronous, active-high reset.
- src_val  in  NUM_SRC  per-source beat valid.
- src_sop  in  NUM_SRC  per-source start of packet.
- src_eop  in  NUM_SRC  per-source end of packet.
- src_mod  in  3*NUM_SRC  per-source valid-byte count on the EOP beat; source i uses bits [3i+2:3i].
- src_data  in  64*NUM_SRC  per-source data; source i uses bits [64i+63:64i].
- src_rdy  out  NUM_SRC  per-source ready. Combinational.
- pkt_tx_full  in  1  MAC FIFO full or almost full.
- pkt_tx_val, pkt_tx_sop, pkt_tx_eop  out  1 each  registered beat qualifiers to the MAC.
- pkt_tx_mod  out  3  registered valid-byte count.
- pkt_tx_data  out  64  registered data.
- err_nosop  out  1  sticky: a non-SOP beat was offered by a source that does not own the bus.
- err_sop_mid  out  1  sticky: an SOP beat was transferred mid-packet.
- pkt_cnt  out  16  count of EOP beats forwarded; wraps.

## Operation
- A transfer on source i occurs when src_val[i] && src_rdy[i] in the same cycle.
- Two states:
  - IDLE: all src_rdy are 0. Candidates are sources with src_val[i] && src_sop[i]. If any exist, register as owner the first candidate found searching from (last_owner+1) mod NUM_SRC upward with wrap, then go to BUSY.
  - BUSY: src_rdy[owner] = !pkt_tx_full; all other src_rdy are 0. On a transfer with src_eop[owner]=1, set last_owner = owner and return to IDLE. Otherwise remain in BUSY.
- Forwarding: on a transfer in cycle t, the next edge registers pkt_tx_val=1 and copies sop, eop, mod and data unmodified. In any cycle without a transfer, the next edge registers pkt_tx_val=0, pkt_tx_sop=0 and pkt_tx_eop=0; data and mod hold their previous values.
- A single-beat packet (sop and eop both 1) is legal. It is forwarded and the state returns to IDLE.
- err_nosop: set in IDLE when any src_val[i] && !src_sop[i]. That beat is never granted and stalls until its source recovers. Cleared only by reset.
- err_sop_mid: set on a BUSY transfer with src_sop[owner]=1 and the state not on the first beat of the packet. The beat is still forwarded unmodified. Cleared only by reset.
- pkt_cnt increments by 1 on every EOP transfer and wraps 0xFFFF -> 0x0000.
- Reset values:
  - state = IDLE.
  - last_owner = NUM_SRC-1, so source 0 wins first.
  - All pkt_tx_* outputs = 0.
  - pkt_cnt = 0; both error flags = 0.
  - src_rdy = 0 while reset is asserted.
- Reset mid-packet: the packet is abandoned immediately. The MAC sees val=0 from the next edge, with no EOP. This truncation is accepted behaviour.

## Timing
- Grant latency: a SOP request first seen in IDLE at cycle t gives BUSY at t+1, so src_rdy[owner] can assert at t+1.
- Output latency: a beat transferred at cycle t appears on pkt_tx_* at t+1. Throughput is 1 beat per cycle while pkt_tx_full=0.
- Inter-packet gap: exactly one IDLE cycle between the EOP transfer and the next grant.
- Backpressure: pkt_tx_full=1 sampled in cycle t forces src_rdy=0 in cycle t. No beat is issued at t+1. Beats already registered are not retracted; the MAC's almost-full margin must absorb one in-flight beat.
- src_rdy depends combinationally on pkt_tx_full, state and owner only. It never depends on src_val, so there is no combinational loop.

## Test plan
- Single source, 3-beat packet (data 0xA0, 0xA1, 0xA2; eop beat mod=5), full=0:
  - src_rdy[0] rises 1 cycle after the request.
  - pkt_tx_val is high for 3 consecutive cycles with sop on beat 1 and eop+mod=5 on beat 3.
  - pkt_cnt = 1.
- Sources 0 and 1 each hold 2-beat packets continuously from reset:
  - Output order is src0, src1, src0, src1.
  - Exactly one idle cycle between packets.
  - Packets are never interleaved.
- pkt_tx_full held high for 4 cycles starting at beat 2 of 4:
  - src_rdy is 0 for those 4 cycles.
  - pkt_tx_val is 0 for 4 cycles starting one cycle later.
  - Resume produces beats 2..4 in order, with no loss or duplication.
- Single-beat packet (sop=eop=1, mod=0) from source 1 only:
  - One output beat with sop=eop=1.
  - State returns to IDLE; pkt_cnt increments.
- Reset asserted during beat 2 of 3:
  - Next edge: pkt_tx_val=0 and pkt_cnt=0.
  - After release, source 0 wins over a simultaneous source 1 request.
- Source 0 offers val=1, sop=0 in IDLE:
  - err_nosop=1 and src_rdy[0] stays 0.
  - A separately injected mid-packet SOP from the owner sets err_sop_mid=1 and is still forwarded.
